sequence_checker: RTL and testbench
===================================

Name: sequence_checker

Overview:
Receive-side counterpart to the 8-byte sequence generator. Consumes the byte stream AF, BC, E2, 78, FF, E2, 0B, 8D, repeating, and aligns to it on the AF start byte. Declares lock after consecutive clean sequences, then flags and counts byte errors. Used as an on-chip/bench monitor on the generator's output bus.

Parameters:
ERR_CNT_W, 8, width of saturating error counter
LOCK_THRESH, 2, consecutive complete clean sequences needed in TRACK to enter LOCKED (range 1..15)
UNLOCK_THRESH, 3, consecutive mismatching beats in LOCKED that force loss of lock (range 1..15)

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  synchronous, active-low reset
data_valid  in  1  beat qualifier; data sampled only when high (generator enable)
data  in  8  received byte
locked  out  1  high while in LOCKED
seq_done  out  1  one-cycle pulse: index-7 beat accepted and matched, in TRACK or LOCKED
err  out  1  one-cycle pulse: mismatching beat accepted in LOCKED
error_count  out  ERR_CNT_W  saturating count of err pulses since reset
expected_idx  out  3  index (0..7) of next expected byte

Behaviour:
- Reset (reset_n low at clk edge): state=SEARCH, expected_idx=0, locked=0, seq_done=0, err=0, error_count=0, good-sequence and miss counters=0. Reset overrides any in-flight beat.
- Beats with data_valid=0 are ignored. All state holds and pulses deassert.
- All outputs are registered and reflect an accepted beat one clk later.
- SEQ[0..7] = AF, BC, E2, 78, FF, E2, 0B, 8D. Match means data==SEQ[expected_idx].
- SEARCH: data==AF → TRACK, idx=1. Any other byte → stay, idx=0. Never asserts err.
- TRACK, match: idx advances modulo 8. At idx 7: seq_done=1, good_cnt+1. If good_cnt+1==LOCK_THRESH → LOCKED, good_cnt=0.
- TRACK, mismatch: → SEARCH, idx=0, good_cnt=0. The mismatching byte is not re-examined (see optional feature). No err pulse.
- LOCKED, match: idx advances, miss_cnt=0, seq_done at idx 7.
- LOCKED, mismatch: err=1, error_count+1 saturating at all-ones, miss_cnt+1, idx still advances (flywheel).
- LOCKED, loss of lock: if miss_cnt+1==UNLOCK_THRESH → SEARCH, locked=0 next cycle, idx=0, miss_cnt=0. err still pulses on that beat.
- idx wrap: 7 → 0 on any accepted beat in TRACK/LOCKED, except on a TRACK mismatch.
- The second E2 (idx 5) is never a start candidate. Only AF aligns.

Optional Feature:
- Macro: SEQUENCE_CHECKER_RESYNC_EN.
- Defined: a mismatching beat in TRACK, or the unlocking beat in LOCKED, whose data==AF goes directly to TRACK with idx=1 and good_cnt=0.
- Undefined: that beat is dropped and the state goes to SEARCH as above.

Decomposition:
- Shared package seq_pkg holds: SEQ_LEN=8, the SEQ_VALUES constant array, the START_BYTE=AF constant, and the checker state enum typedef (SEARCH, TRACK, LOCKED, 2 bits).
- One sub-module, sequence_rom: combinational idx[2:0] → byte lookup built from seq_pkg. It is reusable by the generator so both ends share one table.

Test Plan:
- Reset, then 16 back-to-back valid beats of the sequence from AF → seq_done after beats 8 and 16; locked=1 the cycle after beat 16; error_count=0.
- Same 16 beats with data_valid low for 3 cycles between every beat → identical seq_done/locked results; expected_idx frozen during gaps.
- Locked; send 00 in place of FF (idx 4), then E2 → err pulse once, error_count=1, locked stays 1, E2 matches at idx 5, seq_done on following 8D.
- Locked; send 3 consecutive 00 beats → err pulses 3 times, error_count=3, locked=0 after third, expected_idx=0. Next AF returns to TRACK.
- Leading garbage 12, E2, 34, then sequence → no seq_done or err until the first full AF..8D.
- TRACK at idx 3; send AF → with RESYNC_EN: TRACK, expected_idx=1. Without: SEARCH, expected_idx=0. Also: ERR_CNT_W=2 with 5 errors gives error_count=3. reset_n low mid-sequence clears all outputs next cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the 8-byte sequence generator/checker pair:
// sequence length, the byte table, the alignment byte and checker states.
package seq_pkg;

  localparam int SEQ_LEN = 8;

  localparam logic [7:0] SEQ_VALUES [SEQ_LEN] = '{
    8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D
  };

  // Only the first byte of the pattern is used to align.
  localparam logic [7:0] START_BYTE = 8'hAF;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

endpackage

// File: rtl/sequence_rom.sv
// Combinational index-to-byte lookup of the shared sequence table.
// Used by both the generator and the checker so the two ends agree.
module sequence_rom (
  input  logic [2:0] idx,
  output logic [7:0] value
);
  import seq_pkg::*;

  // Table lookup; the index range exactly covers the table.
  always_comb begin
    value = SEQ_VALUES[idx];
  end

endmodule

// File: rtl/sequence_checker.sv
// Receive-side checker for the 8-byte repeating sequence.
// Aligns on the start byte, locks after LOCK_THRESH clean sequences,
// then flags and counts mismatching bytes; loses lock after
// UNLOCK_THRESH consecutive misses.
// Optional build macro: SEQUENCE_CHECKER_RESYNC_EN -- a mismatching
// start byte in TRACK (or on the unlocking beat) realigns immediately.
module sequence_checker #(
  parameter int ERR_CNT_W     = 8,
  parameter int LOCK_THRESH   = 2,
  parameter int UNLOCK_THRESH = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 data_valid,
  input  logic [7:0]           data,
  output logic                 locked,
  output logic                 seq_done,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] error_count,
  output logic [2:0]           expected_idx
);
  import seq_pkg::*;

  localparam logic [3:0]           LOCK_T   = 4'(LOCK_THRESH);
  localparam logic [3:0]           UNLOCK_T = 4'(UNLOCK_THRESH);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};

  chk_state_e           state_r,    state_n_s;
  logic [2:0]           idx_r,      idx_n_s;
  logic [3:0]           good_r,     good_n_s;
  logic [3:0]           miss_r,     miss_n_s;
  logic [ERR_CNT_W-1:0] cnt_r,      cnt_n_s;
  logic                 locked_r,   seq_done_r, err_r;
  logic                 seq_done_n_s, err_n_s;
  logic [7:0]           rom_byte_s;
  logic                 match_s;
  logic                 resync_s;

  sequence_rom u_rom (
    .idx   (idx_r),
    .value (rom_byte_s)
  );

  assign match_s = (data == rom_byte_s);

`ifdef SEQUENCE_CHECKER_RESYNC_EN
  assign resync_s = (data == START_BYTE);
`else
  assign resync_s = 1'b0;
`endif

  // Next-state, counter and pulse computation for one accepted beat.
  always_comb begin
    state_n_s    = state_r;
    idx_n_s      = idx_r;
    good_n_s     = good_r;
    miss_n_s     = miss_r;
    cnt_n_s      = cnt_r;
    seq_done_n_s = 1'b0;
    err_n_s      = 1'b0;
    if (data_valid) begin
      case (state_r)
        SEARCH: begin
          if (data == START_BYTE) begin
            state_n_s = TRACK;
            idx_n_s   = 3'd1;
          end else begin
            idx_n_s   = 3'd0;
          end
        end
        TRACK: begin
          if (match_s) begin
            idx_n_s = idx_r + 3'd1;
            if (idx_r == 3'd7) begin
              seq_done_n_s = 1'b1;
              if ((good_r + 4'd1) == LOCK_T) begin
                state_n_s = LOCKED;
                good_n_s  = 4'd0;
              end else begin
                good_n_s  = good_r + 4'd1;
              end
            end else begin
              good_n_s = good_r;
            end
          end else begin
            good_n_s = 4'd0;
            if (resync_s) begin
              state_n_s = TRACK;
              idx_n_s   = 3'd1;
            end else begin
              state_n_s = SEARCH;
              idx_n_s   = 3'd0;
            end
          end
        end
        LOCKED: begin
          if (match_s) begin
            idx_n_s      = idx_r + 3'd1;
            miss_n_s     = 4'd0;
            seq_done_n_s = (idx_r == 3'd7);
          end else begin
            err_n_s = 1'b1;
            if (cnt_r != CNT_MAX) begin
              cnt_n_s = cnt_r + ERR_CNT_W'(1);
            end else begin
              cnt_n_s = cnt_r;
            end
            if ((miss_r + 4'd1) == UNLOCK_T) begin
              miss_n_s = 4'd0;
              good_n_s = 4'd0;
              if (resync_s) begin
                state_n_s = TRACK;
                idx_n_s   = 3'd1;
              end else begin
                state_n_s = SEARCH;
                idx_n_s   = 3'd0;
              end
            end else begin
              // Flywheel: keep stepping through the pattern on a miss.
              miss_n_s = miss_r + 4'd1;
              idx_n_s  = idx_r + 3'd1;
            end
          end
        end
        default: begin
          state_n_s = SEARCH;
          idx_n_s   = 3'd0;
          good_n_s  = 4'd0;
          miss_n_s  = 4'd0;
        end
      endcase
    end else begin
      state_n_s = state_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= SEARCH;
      idx_r      <= 3'd0;
      good_r     <= 4'd0;
      miss_r     <= 4'd0;
      cnt_r      <= '0;
      locked_r   <= 1'b0;
      seq_done_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      idx_r      <= idx_n_s;
      good_r     <= good_n_s;
      miss_r     <= miss_n_s;
      cnt_r      <= cnt_n_s;
      locked_r   <= (state_n_s == LOCKED);
      seq_done_r <= seq_done_n_s;
      err_r      <= err_n_s;
    end
  end

  assign locked       = locked_r;
  assign seq_done     = seq_done_r;
  assign err          = err_r;
  assign error_count  = cnt_r;
  assign expected_idx = idx_r;

endmodule

// File: tb/tb_sequence_checker.sv
// Self-checking bench for sequence_checker: a spec-level model checked
// every cycle, plus hand-computed checkpoints on directed vectors.
module tb_sequence_checker;

  localparam int ERR_W  = 8;
  localparam int LOCK   = 2;
  localparam int UNLOCK = 3;
  localparam logic [7:0] SEQ_TB [8] = '{
    8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D
  };

  logic       clk = 1'b0;
  logic       reset_n;
  logic       data_valid;
  logic [7:0] data;
  logic       locked, seq_done, err;
  logic [7:0] error_count;
  logic [2:0] expected_idx;
  logic       locked2, seq_done2, err2;
  logic [1:0] error_count2;
  logic [2:0] expected_idx2;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  always #5 clk = ~clk;

  sequence_checker #(.ERR_CNT_W(ERR_W), .LOCK_THRESH(LOCK), .UNLOCK_THRESH(UNLOCK)) u_dut (
    .clk(clk), .reset_n(reset_n), .data_valid(data_valid), .data(data),
    .locked(locked), .seq_done(seq_done), .err(err),
    .error_count(error_count), .expected_idx(expected_idx)
  );

  sequence_checker #(.ERR_CNT_W(2), .LOCK_THRESH(LOCK), .UNLOCK_THRESH(UNLOCK)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .data_valid(data_valid), .data(data),
    .locked(locked2), .seq_done(seq_done2), .err(err2),
    .error_count(error_count2), .expected_idx(expected_idx2)
  );

  // Model: mode 0=search, 1=track, 2=locked; outputs are what one beat produces.
  typedef struct packed {
    int mode; int idx; int good; int miss; int cnt; bit sd; bit er;
  } mdl_t;

  localparam mdl_t MDL_RST = '{mode: 0, idx: 0, good: 0, miss: 0, cnt: 0, sd: 1'b0, er: 1'b0};

  function automatic mdl_t step(input mdl_t s, input bit v, input logic [7:0] d);
    mdl_t n;
    bit   restart_on_af;
    n = s;
    n.sd = 1'b0;
    n.er = 1'b0;
`ifdef SEQUENCE_CHECKER_RESYNC_EN
    restart_on_af = (d == 8'hAF);
`else
    restart_on_af = 1'b0;
`endif
    if (v) begin
      if (s.mode == 0) begin
        n.mode = (d == 8'hAF) ? 1 : 0;
        n.idx  = (d == 8'hAF) ? 1 : 0;
      end else if (d == SEQ_TB[s.idx]) begin
        n.sd  = (s.idx == 7);
        n.idx = (s.idx + 1) % 8;
        n.miss = 0;
        if (s.mode == 1 && s.idx == 7) begin
          n.good = s.good + 1;
          if (n.good == LOCK) begin
            n.mode = 2;
            n.good = 0;
          end
        end
      end else if (s.mode == 1) begin
        n.good = 0;
        n.mode = restart_on_af ? 1 : 0;
        n.idx  = restart_on_af ? 1 : 0;
      end else begin
        n.er   = 1'b1;
        n.cnt  = (s.cnt + 1 > (1 << ERR_W) - 1) ? s.cnt : s.cnt + 1;
        n.miss = s.miss + 1;
        if (n.miss == UNLOCK) begin
          n.miss = 0;
          n.good = 0;
          n.mode = restart_on_af ? 1 : 0;
          n.idx  = restart_on_af ? 1 : 0;
        end else begin
          n.idx = (s.idx + 1) % 8;
        end
      end
    end
    return n;
  endfunction

  mdl_t m_r = MDL_RST;

  // Advance the model on the same edge the DUT samples.
  always @(posedge clk) begin
    m_r <= (!reset_n) ? MDL_RST : step(m_r, data_valid, data);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("m_locked",   int'(locked),       int'(m_r.mode == 2));
      chk("m_seq_done", int'(seq_done),     int'(m_r.sd));
      chk("m_err",      int'(err),          int'(m_r.er));
      chk("m_count",    int'(error_count),  m_r.cnt);
      chk("m_idx",      int'(expected_idx), m_r.idx);
      chk("m_count2",   int'(error_count2), (m_r.cnt > 3) ? 3 : m_r.cnt);
    end
  end

  task automatic beat(input logic v, input logic [7:0] d);
    data_valid = v;
    data       = d;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    beat(1'b0, 8'h00);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    data_valid = 1'b0;
    data       = 8'h00;
    do_reset();
    armed = 1'b1;
    chk("rst_locked", int'(locked), 0);
    chk("rst_idx",    int'(expected_idx), 0);
    chk("rst_count",  int'(error_count), 0);
    chk("rst_done",   int'(seq_done), 0);

    // 16 back-to-back beats: done after 8 and 16, locked after 16.
    for (int k = 0; k < 16; k++) begin
      beat(1'b1, SEQ_TB[k % 8]);
      if (k == 7) begin
        chk("b2b_done8", int'(seq_done), 1);
        chk("b2b_unlocked8", int'(locked), 0);
      end
    end
    chk("b2b_done16", int'(seq_done), 1);
    chk("b2b_locked", int'(locked), 1);
    chk("b2b_idx", int'(expected_idx), 0);

    // Same beats with 3 idle cycles between each.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      beat(1'b1, SEQ_TB[k % 8]);
      if (k == 7) chk("gap_done8", int'(seq_done), 1);
      for (int g = 0; g < 3; g++) beat(1'b0, 8'h55);
      if (k == 0) chk("gap_idx_frozen", int'(expected_idx), 1);
    end
    chk("gap_locked", int'(locked), 1);

    // Single corrupted byte at index 4 while locked.
    beat(1'b1, 8'hAF); beat(1'b1, 8'hBC); beat(1'b1, 8'hE2); beat(1'b1, 8'h78);
    beat(1'b1, 8'h00);
    chk("one_err", int'(err), 1);
    chk("one_count", int'(error_count), 1);
    chk("one_locked", int'(locked), 1);
    beat(1'b1, 8'hE2);
    chk("one_e2_idx", int'(expected_idx), 6);
    beat(1'b1, 8'h0B); beat(1'b1, 8'h8D);
    chk("one_done", int'(seq_done), 1);

    // Three consecutive misses drop lock.
    for (int k = 0; k < 3; k++) begin
      beat(1'b1, 8'h00);
      chk("miss_err", int'(err), 1);
    end
    chk("miss_unlocked", int'(locked), 0);
    chk("miss_idx", int'(expected_idx), 0);
    chk("miss_count", int'(error_count), 4);
    beat(1'b1, 8'hAF);
    chk("miss_realign_idx", int'(expected_idx), 1);

    // Relock, then a fifth error saturates the 2-bit counter.
    for (int k = 1; k < 16; k++) beat(1'b1, SEQ_TB[k % 8]);
    chk("relock", int'(locked), 1);
    beat(1'b1, 8'h00);
    chk("sat_count8", int'(error_count), 5);
    chk("sat_count2", int'(error_count2), 3);

    // Reset mid-sequence clears everything on the next cycle.
    beat(1'b1, 8'hBC);
    reset_n = 1'b0;
    beat(1'b1, 8'hE2);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_count", int'(error_count), 0);
    chk("mid_rst_idx", int'(expected_idx), 0);
    reset_n = 1'b1;

    // Leading garbage including the non-start E2.
    beat(1'b1, 8'h12); beat(1'b1, 8'hE2); beat(1'b1, 8'h34);
    chk("garbage_idx", int'(expected_idx), 0);
    for (int k = 0; k < 8; k++) begin
      beat(1'b1, SEQ_TB[k]);
      if (k == 6) chk("garbage_no_done", int'(seq_done), 0);
    end
    chk("garbage_done", int'(seq_done), 1);

    // Start byte arriving at index 3 in TRACK.
    do_reset();
    beat(1'b1, 8'hAF); beat(1'b1, 8'hBC); beat(1'b1, 8'hE2);
    chk("track_idx3", int'(expected_idx), 3);
    beat(1'b1, 8'hAF);
`ifdef SEQUENCE_CHECKER_RESYNC_EN
    chk("resync_idx", int'(expected_idx), 1);
`else
    chk("resync_idx", int'(expected_idx), 0);
`endif
    chk("resync_unlocked", int'(locked), 0);

    beat(1'b0, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
